// File: rtl/cell_stim_sequencer_if.sv
// Stimulus/response bundle between a characterization bench and the Gray-code
// cell stimulus sequencer. master = bench/cell side, slave = sequencer.
interface cell_stim_sequencer_if #(
   parameter int N_IN  = 3,
   parameter int CNT_W = 8
);
   logic                   START;
   logic [(1<<N_IN)-1:0]   TRUTH;
   logic                   DUT_Q;
   logic [N_IN-1:0]        STIM;
   logic                   BUSY;
   logic                   DONE;
   logic [CNT_W-1:0]       ERR_CNT;
   logic [CNT_W-1:0]       TOG_CNT;
   logic                   FAIL_VLD;
   logic [N_IN-1:0]        FAIL_VEC;

   modport master (
      output START, TRUTH, DUT_Q,
      input  STIM, BUSY, DONE, ERR_CNT, TOG_CNT, FAIL_VLD, FAIL_VEC
   );

   modport slave (
      input  START, TRUTH, DUT_Q,
      output STIM, BUSY, DONE, ERR_CNT, TOG_CNT, FAIL_VLD, FAIL_VEC
   );
endinterface

// File: rtl/cell_stim_sequencer.sv
// Sweeps all 2^N_IN input vectors of a combinational cell in Gray-code order,
// holding each for HOLD cycles, and scores the sampled output against TRUTH.
module cell_stim_sequencer #(
   parameter int N_IN  = 3,
   parameter int HOLD  = 4,
   parameter int CNT_W = 8
) (
   input logic                    CLK,
   input logic                    RSTB,
   cell_stim_sequencer_if.slave   bus
);
   localparam int HW = (HOLD > 2) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]    HCNT_LAST = HW'(HOLD - 1);
   localparam logic [HW-1:0]    HCNT_ONE  = HW'(1);
   localparam logic [N_IN-1:0]  IDX_ONE   = N_IN'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state_q;
   logic [N_IN-1:0]    idx_q;
   logic [HW-1:0]      hcnt_q;
   logic               prev_q;
   logic [N_IN-1:0]    stim_q;
   logic               busy_q;
   logic               done_q;
   logic [CNT_W-1:0]   err_q;
   logic [CNT_W-1:0]   tog_q;
   logic               fvld_q;
   logic [N_IN-1:0]    fvec_q;

   logic [N_IN-1:0]    cur_vec;
   logic [N_IN-1:0]    idx_d;
   logic               mis;

   function automatic logic [N_IN-1:0] gray(input logic [N_IN-1:0] i);
      return i ^ (i >> 1);
   endfunction

   assign cur_vec = gray(idx_q);
   assign idx_d   = idx_q + IDX_ONE;
   assign mis     = (bus.DUT_Q != bus.TRUTH[cur_vec]);

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hcnt_q  <= '0;
         prev_q  <= 1'b0;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
         tog_q   <= '0;
         fvld_q  <= 1'b0;
         fvec_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.START) begin
                  state_q <= RUN;
                  idx_q   <= '0;
                  hcnt_q  <= '0;
                  stim_q  <= '0;
                  busy_q  <= 1'b1;
                  err_q   <= '0;
                  tog_q   <= '0;
                  fvld_q  <= 1'b0;
                  fvec_q  <= '0;
               end
            end
            RUN: begin
               if (hcnt_q != HCNT_LAST) begin
                  hcnt_q <= hcnt_q + HCNT_ONE;
               end else begin
                  // Sample edge: score this vector, then advance or finish.
                  hcnt_q <= '0;
                  prev_q <= bus.DUT_Q;
                  if (mis) begin
                     if (err_q != '1) err_q <= err_q + CNT_ONE;
                     if (!fvld_q) begin
                        fvld_q <= 1'b1;
                        fvec_q <= cur_vec;
                     end
                  end
                  if ((idx_q != '0) && (bus.DUT_Q != prev_q) && (tog_q != '1))
                     tog_q <= tog_q + CNT_ONE;
                  if (idx_q == '1) begin
                     state_q <= FIN;
                     stim_q  <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q  <= idx_d;
                     stim_q <= gray(idx_d);
                  end
               end
            end
            FIN: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.STIM     = stim_q;
   assign bus.BUSY     = busy_q;
   assign bus.DONE     = done_q;
   assign bus.ERR_CNT  = err_q;
   assign bus.TOG_CNT  = tog_q;
   assign bus.FAIL_VLD = fvld_q;
   assign bus.FAIL_VEC = fvec_q;
endmodule

// File: tb/tb_cell_stim_sequencer.sv
// Scoreboard bench for cell_stim_sequencer: NAND3 cell model and stuck-at
// faults, plus a CNT_W=2 instance for counter saturation.
module tb_cell_stim_sequencer;
   localparam int N = 3;
   localparam int H = 4;

   logic CLK = 1'b0;
   logic RSTB;
   int   mode;   // 0 = NAND3, 1 = stuck-at-1, 2 = stuck-at-0
   int   n_cmp = 0;
   int   n_err = 0;

   typedef struct {
      logic [7:0] err;
      logic [7:0] tog;
      logic       fv;
      logic [2:0] fvec;
   } res_t;

   logic [2:0] stim_sb[$];
   res_t       res_sb[$];

   always #5 CLK = ~CLK;

   cell_stim_sequencer_if #(.N_IN(N), .CNT_W(8)) bus ();
   cell_stim_sequencer_if #(.N_IN(N), .CNT_W(2)) bus2 ();

   cell_stim_sequencer #(.N_IN(N), .HOLD(H), .CNT_W(8)) dut (
      .CLK(CLK), .RSTB(RSTB), .bus(bus.slave)
   );
   cell_stim_sequencer #(.N_IN(N), .HOLD(H), .CNT_W(2)) dut2 (
      .CLK(CLK), .RSTB(RSTB), .bus(bus2.slave)
   );

   assign bus.DUT_Q   = (mode == 0) ? ~&bus.STIM : (mode == 1);
   assign bus2.DUT_Q  = 1'b0;
   assign bus2.START  = bus.START;
   assign bus2.TRUTH  = bus.TRUTH;

   task automatic start_sweep(input logic [7:0] e_err, input logic [7:0] e_tog,
                              input logic e_fv, input logic [2:0] e_fvec);
      res_t r;
      logic [2:0] kk;
      for (int k = 0; k < 8; k++) begin
         kk = k[2:0];
         for (int h = 0; h < H; h++) stim_sb.push_back(kk ^ (kk >> 1));
      end
      r.err = e_err; r.tog = e_tog; r.fv = e_fv; r.fvec = e_fvec;
      res_sb.push_back(r);
      @(negedge CLK) bus.START = 1'b1;
      @(posedge CLK); #1 bus.START = 1'b0;
      n_cmp++;
      if ({bus.ERR_CNT, bus.TOG_CNT, bus.FAIL_VLD, bus.FAIL_VEC} !== 20'h0) begin
         n_err++;
         $display("FAIL start_clear: got err=%0d tog=%0d fv=%0b fvec=%0d want all 0",
                  bus.ERR_CNT, bus.TOG_CNT, bus.FAIL_VLD, bus.FAIL_VEC);
      end
   endtask

   task automatic run_body(input bit repulse, input int rst_at);
      logic [2:0] exp_stim;
      res_t r;
      for (int c = 0; c < 8 * H; c++) begin
         exp_stim = stim_sb.pop_front();
         n_cmp++;
         if (bus.STIM !== exp_stim || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL run_c%0d: got stim=%0d busy=%0b done=%0b want stim=%0d busy=1 done=0",
                     c, bus.STIM, bus.BUSY, bus.DONE, exp_stim);
         end
         if (c == rst_at) begin
            RSTB = 1'b0;
            @(posedge CLK); #1 RSTB = 1'b1;
            n_cmp++;
            if ({bus.STIM, bus.BUSY, bus.DONE, bus.ERR_CNT, bus.TOG_CNT,
                 bus.FAIL_VLD, bus.FAIL_VEC} !== 25'h0) begin
               n_err++;
               $display("FAIL midsweep_reset: got stim=%0d busy=%0b done=%0b err=%0d tog=%0d fv=%0b fvec=%0d want all 0",
                        bus.STIM, bus.BUSY, bus.DONE, bus.ERR_CNT, bus.TOG_CNT,
                        bus.FAIL_VLD, bus.FAIL_VEC);
            end
            repeat (2) @(posedge CLK);
            #1;
            n_cmp++;
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
               n_err++;
               $display("FAIL post_reset_idle: got busy=%0b done=%0b want 0 0", bus.BUSY, bus.DONE);
            end
            stim_sb.delete();
            res_sb.delete();
            return;
         end
         bus.START = repulse && (c == 5 || c == 20);
         @(posedge CLK); #1;
      end
      bus.START = 1'b0;
      r = res_sb.pop_front();
      n_cmp++;
      if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.STIM !== 3'd0) begin
         n_err++;
         $display("FAIL done_pulse: got done=%0b busy=%0b stim=%0d want 1 0 0",
                  bus.DONE, bus.BUSY, bus.STIM);
      end
      n_cmp++;
      if (bus.ERR_CNT !== r.err || bus.TOG_CNT !== r.tog ||
          bus.FAIL_VLD !== r.fv || bus.FAIL_VEC !== r.fvec) begin
         n_err++;
         $display("FAIL results: got err=%0d tog=%0d fv=%0b fvec=%0d want err=%0d tog=%0d fv=%0b fvec=%0d",
                  bus.ERR_CNT, bus.TOG_CNT, bus.FAIL_VLD, bus.FAIL_VEC,
                  r.err, r.tog, r.fv, r.fvec);
      end
      bus.START = repulse;
      @(posedge CLK); #1 bus.START = 1'b0;
      n_cmp++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL done_once: got done=%0b busy=%0b want 0 0", bus.DONE, bus.BUSY);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (bus.BUSY !== 1'b0 || bus.ERR_CNT !== r.err || bus.TOG_CNT !== r.tog) begin
         n_err++;
         $display("FAIL idle_hold: got busy=%0b err=%0d tog=%0d want busy=0 err=%0d tog=%0d",
                  bus.BUSY, bus.ERR_CNT, bus.TOG_CNT, r.err, r.tog);
      end
   endtask

   task automatic test_reset();
      RSTB = 1'b0; bus.START = 1'b0; bus.TRUTH = 8'h7F; mode = 0;
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++;
      if ({bus.STIM, bus.BUSY, bus.DONE, bus.ERR_CNT, bus.TOG_CNT,
           bus.FAIL_VLD, bus.FAIL_VEC} !== 25'h0) begin
         n_err++;
         $display("FAIL reset_state: got stim=%0d busy=%0b done=%0b err=%0d tog=%0d fv=%0b fvec=%0d want all 0",
                  bus.STIM, bus.BUSY, bus.DONE, bus.ERR_CNT, bus.TOG_CNT, bus.FAIL_VLD, bus.FAIL_VEC);
      end
      n_cmp++;
      if ({bus2.ERR_CNT, bus2.BUSY} !== 3'b0) begin
         n_err++;
         $display("FAIL reset_state_w2: got err=%0d busy=%0b want 0 0", bus2.ERR_CNT, bus2.BUSY);
      end
      RSTB = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_golden();
      mode = 0;
      start_sweep(8'd0, 8'd2, 1'b0, 3'd0);
      run_body(1'b0, -1);
   endtask

   task automatic test_stuck1();
      mode = 1;
      start_sweep(8'd1, 8'd0, 1'b1, 3'b111);
      run_body(1'b0, -1);
   endtask

   task automatic test_stuck0();
      mode = 2;
      start_sweep(8'd7, 8'd0, 1'b1, 3'b000);
      run_body(1'b0, -1);
      n_cmp++;
      if (bus2.ERR_CNT !== 2'b11 || bus2.FAIL_VLD !== 1'b1 || bus2.FAIL_VEC !== 3'd0 ||
          bus2.TOG_CNT !== 2'd0) begin
         n_err++;
         $display("FAIL sat_w2: got err=%0d fv=%0b fvec=%0d tog=%0d want err=3 fv=1 fvec=0 tog=0",
                  bus2.ERR_CNT, bus2.FAIL_VLD, bus2.FAIL_VEC, bus2.TOG_CNT);
      end
   endtask

   task automatic test_start_ignored();
      mode = 0;
      start_sweep(8'd0, 8'd2, 1'b0, 3'd0);
      run_body(1'b1, -1);
   endtask

   task automatic test_midsweep_reset();
      mode = 0;
      start_sweep(8'd0, 8'd2, 1'b0, 3'd0);
      run_body(1'b0, 13);
      start_sweep(8'd0, 8'd2, 1'b0, 3'd0);
      run_body(1'b0, -1);
   endtask

   task automatic test_back_to_back();
      mode = 2;
      start_sweep(8'd7, 8'd0, 1'b1, 3'b000);
      run_body(1'b0, -1);
      n_cmp++;
      if (bus.ERR_CNT !== 8'd7 || bus.FAIL_VLD !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_prior: got err=%0d fv=%0b want err=7 fv=1", bus.ERR_CNT, bus.FAIL_VLD);
      end
      mode = 0;
      start_sweep(8'd0, 8'd2, 1'b0, 3'd0);
      run_body(1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_golden();
      test_stuck1();
      test_stuck0();
      test_start_ignored();
      test_midsweep_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cell_stim_sequencer.md
Name: cell_stim_sequencer

Overview:
- Drives exhaustive input patterns into an N-input combinational standard cell under power/functional test, and collects the cell's response.
- Applies all 2^N vectors in Gray-code order, so exactly one input toggles per step. Each vector is held for HOLD cycles.
- Samples the cell output once per vector, compares it against a supplied truth table, and counts mismatches and output toggles.
- Sits on the stimulus side of the cell in the characterization bench; its STIM bus connects directly to the cell inputs.

Parameters:
- N_IN, 3, number of cell inputs driven (1..8).
- HOLD, 4, cycles each vector is applied (>=2).
- CNT_W, 8, width of ERR_CNT and TOG_CNT; both counters saturate at all-ones.

Ports:
- CLK  input  1  rising-edge clock.
- RSTB  input  1  synchronous active-low reset.
- START  input  1  begin a sweep; sampled only in IDLE.
- TRUTH  input  2^N_IN  expected output; bit j is the expected value for input vector j. Must be stable while BUSY.
- DUT_Q  input  1  output of the cell under test.
- STIM  output  N_IN  input vector driven to the cell.
- BUSY  output  1  high while a sweep is in progress.
- DONE  output  1  one-cycle pulse when a sweep completes.
- ERR_CNT  output  CNT_W  number of mismatching vectors in the last sweep.
- TOG_CNT  output  CNT_W  number of DUT_Q changes between consecutive sampled vectors.
- FAIL_VLD  output  1  at least one mismatch occurred in the last sweep.
- FAIL_VEC  output  N_IN  first mismatching vector (STIM value, not the index).

Behaviour:
- Reset (RSTB=0 at a rising edge):
  - State goes to IDLE.
  - STIM, BUSY, DONE, ERR_CNT, TOG_CNT, FAIL_VLD and FAIL_VEC all go to 0.
  - Internal idx, hcnt and prev-sample registers clear.
  - Reset applies identically mid-sweep; the aborted sweep leaves no result.
- States: IDLE, RUN, FIN.
- IDLE:
  - BUSY=0, STIM=0.
  - Results from the previous sweep are held.
  - START=1 at an edge moves to RUN. On that same edge: idx=0, hcnt=0, STIM=gray(0)=0, BUSY=1, and ERR_CNT, TOG_CNT, FAIL_VLD and FAIL_VEC clear.
- RUN, at each edge:
  - If hcnt<HOLD-1: hcnt increments.
  - If hcnt==HOLD-1 (sample edge):
    - Sample DUT_Q as s.
    - If s != TRUTH[gray(idx)]: ERR_CNT increments (saturating). If FAIL_VLD=0, set FAIL_VLD=1 and FAIL_VEC=gray(idx).
    - If idx>0 and s != prev: TOG_CNT increments (saturating).
    - prev=s, hcnt=0.
    - If idx==2^N_IN-1: go to FIN with STIM=0 and BUSY=0.
    - Otherwise: idx increments and STIM=gray(idx+1).
- FIN: DONE=1 for exactly one cycle, then go to IDLE. START during FIN is ignored.
- gray(i) = i XOR (i>>1), width N_IN.
- START while BUSY is ignored. A sweep cannot be restarted mid-run; only reset aborts it.
- Timing: with START accepted at edge t0, each vector is on STIM for exactly HOLD cycles. The sample is taken at the edge that ends the hold window. DONE is high in the cycle following edge t0+2^N_IN*HOLD.
- The first vector never contributes a toggle, so at most 2^N_IN-1 toggles are counted.
- There is no combinational path from inputs to outputs; all outputs are registered.

Test Plan (N_IN=3, HOLD=4, CNT_W=8 unless stated):
- Golden NAND3 model on DUT_Q, TRUTH=8'h7F, START pulse → required:
  - STIM sequence 0,1,3,2,6,7,5,4, each held 4 cycles.
  - DONE pulses 32 cycles after the START edge.
  - ERR_CNT=0, FAIL_VLD=0, TOG_CNT=2.
- DUT_Q stuck at 1, TRUTH=8'h7F → ERR_CNT=1, FAIL_VLD=1, FAIL_VEC=3'b111, TOG_CNT=0.
- DUT_Q stuck at 0, TRUTH=8'h7F → ERR_CNT=7, FAIL_VEC=3'b000, TOG_CNT=0. Repeat with CNT_W=2 → ERR_CNT=3 (saturated).
- START re-pulsed at cycles 5 and 20 of a sweep, and again during FIN → ignored. Single DONE at cycle 32; results identical to the first scenario.
- RSTB=0 for one edge at cycle 13 of a sweep → next cycle all outputs are 0 and state is IDLE. A new START then completes a full clean sweep with golden results.
- Back-to-back sweeps: the first with stuck-at-0, then START with the golden model → counters and FAIL_VLD clear on the START edge; final ERR_CNT=0, TOG_CNT=2.
